// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;
  localparam int C_DATA_WIDTH = 32;
  localparam int C_ADDR_WIDTH = 11;
  localparam int C_PC_STEP = 4;
  localparam logic [C_DATA_WIDTH-1:0] C_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [C_DATA_WIDTH-1:0] instr;
    logic [C_ADDR_WIDTH-1:0] pc;
    logic [C_ADDR_WIDTH-1:0] pc_plus4;
  } if_id_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - PC register, next-PC select and redirect alignment
// FETCH_MISALIGN_CHECK_EN keeps raw misaligned targets and raises o_misaligned.
module fetch_pc_reg #(
  parameter int P_ADDR_WIDTH = 11,
  parameter logic [P_ADDR_WIDTH-1:0] P_RESET_PC = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_advance,
  input  logic                    i_redirect,
  input  logic [P_ADDR_WIDTH-1:0] i_redirect_pc,
  output logic [P_ADDR_WIDTH-1:0] o_pc,
  output logic                    o_misaligned
);
  import fetch_pkg::*;

  logic [P_ADDR_WIDTH-1:0] pc;
  logic [P_ADDR_WIDTH-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;

  assign target = i_redirect_pc;

  // Only a redirect can change the flag, so a fault sticks until software retargets.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      misaligned <= 1'b0;
    end else if (i_redirect) begin
      misaligned <= (i_redirect_pc[1:0] != 2'b00);
    end
  end

  assign o_misaligned = misaligned;
`else
  assign target = i_redirect_pc & {{(P_ADDR_WIDTH-2){1'b1}}, 2'b00};
  assign o_misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc <= P_RESET_PC;
    end else if (i_redirect) begin
      pc <= target;
    end else if (i_advance) begin
      pc <= pc + P_ADDR_WIDTH'(C_PC_STEP);
    end
  end

  assign o_pc = pc;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, ROM address, IF/ID register and fetch counter
// Optional FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect fault.
module fetch_unit #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 11,
  parameter logic [P_ADDR_WIDTH-1:0] P_RESET_PC = '0,
  parameter int P_CNT_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic [P_ADDR_WIDTH-1:0] o_pc,
  input  logic [P_DATA_WIDTH-1:0] i_instr,
  input  logic                    i_stall,
  input  logic                    i_redirect,
  input  logic [P_ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                    o_if_valid,
  input  logic                    i_if_ready,
  output logic [P_DATA_WIDTH-1:0] o_if_instr,
  output logic [P_ADDR_WIDTH-1:0] o_if_pc,
  output logic [P_ADDR_WIDTH-1:0] o_if_pc_plus4,
  output logic                    o_misaligned,
  output logic [P_CNT_WIDTH-1:0]  o_fetch_count
);
  import fetch_pkg::*;

  logic                    advance;
  logic [P_ADDR_WIDTH-1:0] pc;
  logic                    misaligned;

  // A pending misaligned fault blocks fetch so no garbage word reaches decode.
  assign advance = !i_stall && (!o_if_valid || i_if_ready) && !misaligned;

  fetch_pc_reg #(
    .P_ADDR_WIDTH (P_ADDR_WIDTH),
    .P_RESET_PC   (P_RESET_PC)
  ) u_pc_reg (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_advance     (advance),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_pc          (pc),
    .o_misaligned  (misaligned)
  );

  assign o_pc = pc;
  assign o_misaligned = misaligned;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_if_valid    <= 1'b0;
      o_if_instr    <= '0;
      o_if_pc       <= '0;
      o_if_pc_plus4 <= '0;
      o_fetch_count <= '0;
    end else if (i_redirect) begin
      o_if_valid <= 1'b0;
    end else if (advance) begin
      o_if_valid    <= 1'b1;
      o_if_instr    <= i_instr;
      o_if_pc       <= pc;
      o_if_pc_plus4 <= pc + P_ADDR_WIDTH'(C_PC_STEP);
      o_fetch_count <= o_fetch_count + P_CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (FETCH_MISALIGN_CHECK_EN aware)
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [10:0] if_pc;
  logic [10:0] if_pc_plus4;
  logic        misaligned;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [10:0] pc;
    logic [10:0] pc4;
  } exp_t;
  exp_t q[$];

  int n_xfer = 0;
  int n_drop = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_pc          (pc),
    .i_instr       (instr),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_if_valid    (if_valid),
    .i_if_ready    (if_ready),
    .o_if_instr    (if_instr),
    .o_if_pc       (if_pc),
    .o_if_pc_plus4 (if_pc_plus4),
    .o_misaligned  (misaligned),
    .o_fetch_count (fetch_count)
  );

  function automatic logic [31:0] rom_word(logic [10:0] a);
    return 32'hC0DE_0000 ^ {21'h0, a};
  endfunction

  assign instr = rom_word(pc);

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected stream after a (re)start: consecutive words from the aligned start address.
  function automatic void fill(logic [10:0] start);
    logic [10:0] a;
    exp_t e;
    q.delete();
    a = start & 11'h7FC;
    for (int i = 0; i < 64; i++) begin
      e.instr = rom_word(a);
      e.pc    = a;
      e.pc4   = a + 11'd4;
      q.push_back(e);
      a = a + 11'd4;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every word ever loaded was either consumed, dropped by a redirect, or is still held.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_xfer = 0;
      n_drop = 0;
    end else begin
      chk("fetch_count_vs_model", fetch_count, n_xfer + n_drop + (if_valid ? 1 : 0));
      if (redirect) begin
        if (if_valid) n_drop++;
      end else if (if_valid && if_ready && !stall) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=empty required=entry at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("sb_instr", if_instr, e.instr);
          chk("sb_pc", if_pc, e.pc);
          chk("sb_pc_plus4", if_pc_plus4, e.pc4);
        end
        n_xfer++;
      end
    end
  end

  initial begin
    logic [31:0] s_instr;
    logic [10:0] s_pc;
    logic [10:0] s_opc;
    logic [31:0] s_cnt;
    int since;
    logic [10:0] tgt;

    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    step();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_pc_plus4", if_pc_plus4, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_misaligned", misaligned, 0);

    fill(11'h000);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_valid", if_valid, 1);
      chk("seq_if_pc", if_pc, 11'(4 * k));
      chk("seq_count", fetch_count, k + 1);
    end

    if_ready = 1'b0;
    s_instr = if_instr;
    s_pc = if_pc;
    s_opc = pc;
    s_cnt = fetch_count;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_valid", if_valid, 1);
      chk("hold_instr", if_instr, s_instr);
      chk("hold_if_pc", if_pc, s_pc);
      chk("hold_pc", pc, s_opc);
      chk("hold_count", fetch_count, s_cnt);
    end
    if_ready = 1'b1;
    step();
    chk("resume_if_pc", if_pc, 11'h00C);

    redirect = 1'b1;
    redirect_pc = 11'h100;
    fill(11'h100);
    step();
    chk("redir_valid", if_valid, 0);
    redirect = 1'b0;
    step();
    chk("redir_if_pc", if_pc, 11'h100);
    chk("redir_valid_back", if_valid, 1);

    redirect = 1'b1;
    redirect_pc = 11'h7F8;
    fill(11'h7F8);
    step();
    redirect = 1'b0;
    step();
    chk("wrap_pc_7f8", if_pc, 11'h7F8);
    step();
    chk("wrap_pc_7fc", if_pc, 11'h7FC);
    chk("wrap_plus4", if_pc_plus4, 11'h000);
    step();
    chk("wrap_next", if_pc, 11'h000);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect = 1'b1;
    redirect_pc = 11'h102;
    q.delete();
    step();
    chk("mis_flag", misaligned, 1);
    chk("mis_raw_pc", pc, 11'h102);
    chk("mis_valid", if_valid, 0);
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mis_hold_valid", if_valid, 0);
      chk("mis_hold_pc", pc, 11'h102);
    end
    redirect = 1'b1;
    redirect_pc = 11'h040;
    fill(11'h040);
    step();
    chk("mis_clear", misaligned, 0);
    redirect = 1'b0;
    step();
    chk("mis_recover_pc", if_pc, 11'h040);
`else
    redirect = 1'b1;
    redirect_pc = 11'h102;
    fill(11'h100);
    step();
    chk("mis_tied0", misaligned, 0);
    chk("mis_forced_pc", pc, 11'h100);
    redirect = 1'b0;
    step();
    chk("mis_if_pc", if_pc, 11'h100);
`endif

    since = 40;
    for (int c = 0; c < 600; c++) begin
      if_ready = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 9) < 2);
      if (since >= 40 || $urandom_range(0, 19) == 0) begin
        tgt = 11'($urandom_range(0, 2047));
`ifdef FETCH_MISALIGN_CHECK_EN
        tgt = tgt & 11'h7FC;
`endif
        redirect = 1'b1;
        redirect_pc = tgt;
        fill(tgt);
        since = 0;
      end else begin
        redirect = 1'b0;
        since++;
      end
      step();
    end
    redirect = 1'b0;

    stall = 1'b1;
    if_ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_valid", if_valid, 0);
    chk("arst_instr", if_instr, 0);
    chk("arst_if_pc", if_pc, 0);
    chk("arst_plus4", if_pc_plus4, 0);
    chk("arst_count", fetch_count, 0);
    chk("arst_misaligned", misaligned, 0);
    step();
    fill(11'h000);
    stall = 1'b0;
    if_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("restart_if_pc", if_pc, 11'h000);
    chk("restart_count", fetch_count, 1);
    step();
    chk("restart_next", if_pc, 11'h004);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
